// File: rtl/mp_add_pkg.sv
// mp_add_pkg: shared width, state encoding and word-select helper for the multi-precision adder
package mp_add_pkg;
  localparam int WORD_W = 32;
  localparam int MAX_WORDS = 16;
  typedef logic [MAX_WORDS*WORD_W-1:0] wide_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic logic [WORD_W-1:0] word_sel(input wide_t v, input int unsigned i);
    return v[i*WORD_W +: WORD_W];
  endfunction
endpackage

// File: rtl/mp_add_sequencer_if.sv
// mp_add_sequencer_if: operand/result valid-ready bundle between requester and sequencer
interface mp_add_sequencer_if #(
  parameter int WORDS = 4
);
  import mp_add_pkg::*;
  logic in_valid;
  logic in_ready;
  logic op_sub;
  logic op_cin;
  logic out_valid;
  logic out_ready;
  logic res_cout;
  logic res_ovf;
  logic [WORDS*WORD_W-1:0] op_a;
  logic [WORDS*WORD_W-1:0] op_b;
  logic [WORDS*WORD_W-1:0] res_sum;
  modport master(
    output in_valid, op_sub, op_a, op_b, op_cin, out_ready,
    input  in_ready, out_valid, res_sum, res_cout, res_ovf
  );
  modport slave(
    input  in_valid, op_sub, op_a, op_b, op_cin, out_ready,
    output in_ready, out_valid, res_sum, res_cout, res_ovf
  );
endinterface

// File: rtl/mp_add_sequencer_cla.sv
// Carry_look_ahead_adder: 32-bit adder built from 4-bit carry-look-ahead groups
module Carry_look_ahead_adder
  import mp_add_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic [WORD_W-1:0] sum,
  output logic              cout
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] cc;
  logic       c;
  always_comb begin
    sum = '0;
    g = '0;
    p = '0;
    cc = '0;
    c = cin;
    for (int k = 0; k < WORD_W; k += 4) begin
      g = a[k+:4] & b[k+:4];
      p = a[k+:4] ^ b[k+:4];
      cc[0] = c;
      cc[1] = g[0] | (p[0] & c);
      cc[2] = g[1] | (p[1] & g[0]) | (&p[1:0] & c);
      cc[3] = g[2] | (p[2] & g[1]) | (&p[2:1] & g[0]) | (&p[2:0] & c);
      cc[4] = g[3] | (p[3] & g[2]) | (&p[3:2] & g[1]) | (&p[3:1] & g[0]) | (&p & c);
      sum[k+:4] = p ^ cc[3:0];
      c = cc[4];
    end
    cout = c;
  end
endmodule

// File: rtl/mp_adder_top.sv
// mp_adder_top: sequencer wired to its carry-look-ahead adder datapath
module mp_adder_top
  import mp_add_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  mp_add_sequencer_if.slave bus
);
  logic [WORD_W-1:0] a;
  logic [WORD_W-1:0] b;
  logic [WORD_W-1:0] s;
  logic              ci;
  logic              co;
  mp_add_sequencer #(.WORDS(WORDS)) u_seq (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .add_a(a),
    .add_b(b),
    .add_cin(ci),
    .add_sum(s),
    .add_cout(co)
  );
  Carry_look_ahead_adder u_cla (
    .a(a),
    .b(b),
    .cin(ci),
    .sum(s),
    .cout(co)
  );
endmodule

// File: rtl/mp_add_sequencer.sv
// mp_add_sequencer: multi-precision add/sub by sequencing one external 32-bit adder word by word
module mp_add_sequencer
  import mp_add_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  mp_add_sequencer_if.slave bus,
  output logic [WORD_W-1:0] add_a,
  output logic [WORD_W-1:0] add_b,
  output logic              add_cin,
  input  logic [WORD_W-1:0] add_sum,
  input  logic              add_cout
);
  localparam int IW = $clog2(WORDS);
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);
  state_t state;
  state_t state_n;
  wide_t a_r;
  wide_t b_r;
  logic sub_r;
  logic carry;
  logic cout_r;
  logic ovf_r;
  logic [IW-1:0] idx;
  logic [WORDS*WORD_W-1:0] sum_r;
  logic [WORD_W-1:0] bw;
  logic a_msb;
  assign a_msb = a_r[WORDS*WORD_W-1];
  assign bus.res_sum = sum_r;
  assign bus.res_cout = cout_r;
  assign bus.res_ovf = ovf_r;
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb
    state_n = state == IDLE ? (bus.in_valid ? RUN : IDLE)
            : state == RUN  ? (idx == LAST ? DONE : RUN)
            : (bus.out_ready ? IDLE : DONE);
  always_comb begin
    bw = word_sel(b_r, 32'(idx)) ^ {WORD_W{sub_r}};
    bus.in_ready = state == IDLE;
    bus.out_valid = state == DONE;
    add_a = state == RUN ? word_sel(a_r, 32'(idx)) : '0;
    add_b = state == RUN ? bw : '0;
    add_cin = state == RUN && carry;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      carry <= 1'b0;
      sum_r <= '0;
      cout_r <= 1'b0;
      ovf_r <= 1'b0;
    end else if (state == IDLE && bus.in_valid) begin
      a_r <= wide_t'(bus.op_a);
      b_r <= wide_t'(bus.op_b);
      sub_r <= bus.op_sub;
      carry <= bus.op_cin ^ bus.op_sub;
      idx <= '0;
    end else if (state == RUN) begin
      sum_r[idx*WORD_W +: WORD_W] <= add_sum;
      carry <= add_cout;
      if (idx == LAST) begin
        cout_r <= add_cout ^ sub_r;
        ovf_r <= (a_msb == bw[WORD_W-1]) && (add_sum[WORD_W-1] != a_msb);
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mp_add_sequencer.sv
// tb_mp_add_sequencer: integrated top and bare sequencer checked against a wide-arithmetic model
module tb_mp_add_sequencer;
  localparam int WORDS = 4;
  localparam int W = WORDS * 32;
  logic clk;
  logic rst;
  logic in_valid;
  logic op_sub;
  logic op_cin;
  logic out_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [31:0] s_a;
  logic [31:0] s_b;
  logic [31:0] s_sum;
  logic s_cin;
  logic s_cout;
  int checks = 0;
  int failures = 0;
  bit chk_en = 0;
  logic busy;
  logic done;
  int cnt;
  logic [W-1:0] m_a;
  logic [W-1:0] m_bp;
  logic m_c0;
  logic [W-1:0] exp_sum;
  logic exp_cout;
  logic exp_ovf;
  logic [W+1:0] sx;
  logic [W:0] msk;
  logic [W:0] lo;
  int sh;
  mp_add_sequencer_if #(.WORDS(WORDS)) bi1 ();
  mp_add_sequencer_if #(.WORDS(WORDS)) bi2 ();
  assign bi1.in_valid = in_valid;
  assign bi1.op_sub = op_sub;
  assign bi1.op_a = op_a;
  assign bi1.op_b = op_b;
  assign bi1.op_cin = op_cin;
  assign bi1.out_ready = out_ready;
  assign bi2.in_valid = in_valid;
  assign bi2.op_sub = op_sub;
  assign bi2.op_a = op_a;
  assign bi2.op_b = op_b;
  assign bi2.op_cin = op_cin;
  assign bi2.out_ready = out_ready;
  assign {s_cout, s_sum} = {1'b0, s_a} + {1'b0, s_b} + 33'(s_cin);
  mp_adder_top #(.WORDS(WORDS)) u_top (
    .clk(clk),
    .rst(rst),
    .bus(bi1)
  );
  mp_add_sequencer #(.WORDS(WORDS)) u_seq (
    .clk(clk),
    .rst(rst),
    .bus(bi2),
    .add_a(s_a),
    .add_b(s_b),
    .add_cin(s_cin),
    .add_sum(s_sum),
    .add_cout(s_cout)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [W-1:0] rnd_op();
    logic [W-1:0] v = '0;
    for (int i = 0; i < WORDS; i++) begin
      int unsigned s = $urandom_range(0, 4);
      v[i*32 +: 32] = s == 0 ? 32'h0 : s == 1 ? 32'hFFFFFFFF : s == 2 ? 32'h7FFFFFFF
                    : s == 3 ? 32'h80000000 : $urandom;
    end
    return v;
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      busy = 0;
      done = 0;
      cnt = 0;
    end else if (busy) begin
      cnt++;
      if (cnt == WORDS) begin
        busy = 0;
        done = 1;
      end
    end else if (done) begin
      if (out_ready) done = 0;
    end else if (in_valid) begin
      m_a = op_a;
      m_bp = op_sub ? ~op_b : op_b;
      m_c0 = op_cin ^ op_sub;
      if (op_sub) begin
        exp_sum = op_a - op_b - W'(op_cin);
        exp_cout = ({1'b0, op_b} + (W+1)'(op_cin)) > {1'b0, op_a};
        sx = {{2{op_a[W-1]}}, op_a} - {{2{op_b[W-1]}}, op_b} - (W+2)'(op_cin);
      end else begin
        {exp_cout, exp_sum} = {1'b0, op_a} + {1'b0, op_b} + (W+1)'(op_cin);
        sx = {{2{op_a[W-1]}}, op_a} + {{2{op_b[W-1]}}, op_b} + (W+2)'(op_cin);
      end
      exp_ovf = sx[W+1:W-1] != 3'b000 && sx[W+1:W-1] != 3'b111;
      busy = 1;
      cnt = 0;
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      chk("top_in_ready", W'(bi1.in_ready), W'(!busy && !done));
      chk("seq_in_ready", W'(bi2.in_ready), W'(!busy && !done));
      chk("top_out_valid", W'(bi1.out_valid), W'(done));
      chk("seq_out_valid", W'(bi2.out_valid), W'(done));
      if (done) begin
        chk("top_sum", bi1.res_sum, exp_sum);
        chk("top_cout", W'(bi1.res_cout), W'(exp_cout));
        chk("top_ovf", W'(bi1.res_ovf), W'(exp_ovf));
        chk("seq_sum", bi2.res_sum, exp_sum);
        chk("seq_cout", W'(bi2.res_cout), W'(exp_cout));
        chk("seq_ovf", W'(bi2.res_ovf), W'(exp_ovf));
      end
      if (busy) begin
        sh = 32 * cnt;
        msk = ((W+1)'(1) << sh) - (W+1)'(1);
        lo = ({1'b0, m_a} & msk) + ({1'b0, m_bp} & msk) + (W+1)'(m_c0);
        chk("add_a", W'(s_a), W'(m_a[sh +: 32]));
        chk("add_b", W'(s_b), W'(m_bp[sh +: 32]));
        chk("add_cin", W'(s_cin), W'(lo[sh]));
      end else begin
        chk("add_a_idle", W'(s_a), W'(0));
        chk("add_b_idle", W'(s_b), W'(0));
        chk("add_cin_idle", W'(s_cin), W'(0));
      end
    end
  end
  task automatic op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic sub, input logic cin,
                    input logic [W-1:0] es, input logic ec, input logic eo);
    int n = 0;
    while (!bi1.in_ready && n < 50) begin
      tick();
      n++;
    end
    chk({name, "_in_ready"}, W'(bi1.in_ready), W'(1));
    op_a = a;
    op_b = b;
    op_sub = sub;
    op_cin = cin;
    out_ready = 1;
    in_valid = 1;
    tick();
    in_valid = 0;
    n = 1;
    while (!bi1.out_valid && n < 50) begin
      tick();
      n++;
    end
    chk({name, "_latency"}, W'(n), W'(WORDS + 1));
    chk({name, "_sum"}, bi1.res_sum, es);
    chk({name, "_cout"}, W'(bi1.res_cout), W'(ec));
    chk({name, "_ovf"}, W'(bi1.res_ovf), W'(eo));
    chk({name, "_seq_sum"}, bi2.res_sum, es);
    chk({name, "_model_sum"}, exp_sum, es);
    chk({name, "_model_cout"}, W'(exp_cout), W'(ec));
    chk({name, "_model_ovf"}, W'(exp_ovf), W'(eo));
    tick();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    rst = 1;
    in_valid = 0;
    op_sub = 0;
    op_cin = 0;
    op_a = '0;
    op_b = '0;
    out_ready = 1;
    repeat (3) tick();
    rst = 0;
    chk_en = 1;
    chk("rst_in_ready", W'(bi1.in_ready), W'(1));
    chk("rst_out_valid", W'(bi1.out_valid), W'(0));
    chk("rst_sum", bi1.res_sum, W'(0));
    chk("rst_cout", W'(bi1.res_cout), W'(0));
    chk("rst_ovf", W'(bi1.res_ovf), W'(0));
    op("wrap", {W{1'b1}}, W'(1), 0, 0, W'(0), 1, 0);
    op("xword", W'(64'hFFFFFFFF_FFFFFFFF), W'(1), 0, 0, W'(65'h1_00000000_00000000), 0, 0);
    op("sub_borrow", W'(33'h1_00000000), W'(1), 1, 0, W'(32'hFFFFFFFF), 0, 0);
    op("sub_neg", W'(0), W'(1), 1, 0, {W{1'b1}}, 1, 0);
    op("ovf", {1'b0, {(W-1){1'b1}}}, W'(1), 0, 0, {1'b1, {(W-1){1'b0}}}, 0, 1);
    out_ready = 0;
    op_a = W'(64'hFFFFFFFF_FFFFFFFF);
    op_b = W'(1);
    op_sub = 0;
    op_cin = 0;
    in_valid = 1;
    tick();
    in_valid = 0;
    n = 0;
    while (!bi1.out_valid && n < 50) begin
      tick();
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = 1;
      op_a = rnd_op();
      op_b = rnd_op();
      op_sub = 1'($urandom);
      tick();
      chk("bp_out_valid", W'(bi1.out_valid), W'(1));
      chk("bp_in_ready", W'(bi1.in_ready), W'(0));
      chk("bp_sum", bi1.res_sum, W'(65'h1_00000000_00000000));
      chk("bp_cout", W'(bi1.res_cout), W'(0));
    end
    in_valid = 0;
    out_ready = 1;
    tick();
    chk("bp_release", W'(bi1.in_ready), W'(1));
    op("after_bp", W'(5), W'(3), 1, 1, W'(1), 0, 0);
    op_a = rnd_op();
    op_b = rnd_op();
    in_valid = 1;
    tick();
    in_valid = 0;
    repeat (2) tick();
    rst = 1;
    tick();
    rst = 0;
    chk("mid_rst_in_ready", W'(bi1.in_ready), W'(1));
    chk("mid_rst_out_valid", W'(bi1.out_valid), W'(0));
    chk("mid_rst_add_a", W'(s_a), W'(0));
    chk("mid_rst_add_b", W'(s_b), W'(0));
    chk("mid_rst_add_cin", W'(s_cin), W'(0));
    op("after_rst", W'(10), W'(20), 0, 1, W'(31), 0, 0);
    for (int i = 0; i < 800; i++) begin
      in_valid = 1'($urandom);
      op_sub = 1'($urandom);
      op_cin = 1'($urandom);
      op_a = rnd_op();
      op_b = rnd_op();
      out_ready = $urandom_range(0, 3) != 0;
      rst = $urandom_range(0, 99) == 0;
      tick();
    end
    rst = 0;
    in_valid = 0;
    out_ready = 1;
    repeat (WORDS + 4) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mp_add_sequencer.md
Name: mp_add_sequencer

Overview:
Sequences a single 32-bit combinational carry-look-ahead adder across WORDS cycles to perform multi-precision add/subtract of WORDS*32-bit operands. Carry is chained word-by-word, least significant word first. Uses a valid/ready handshake on both the operand and result sides. Sits between a requester (e.g. a crypto/bignum engine) and the shared adder datapath; the adder is external and driven through the add_* ports.

Parameters:
WORDS, 4, number of 32-bit words per operand (2..16)
WORD_W, 32, adder width; fixed to the adder datapath width

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operand request valid
in_ready  out  1  block idle, can accept operands
op_sub  in  1  0 = A+B+cin, 1 = A-B-cin
op_a  in  WORDS*WORD_W  operand A, word 0 = bits [31:0]
op_b  in  WORDS*WORD_W  operand B
op_cin  in  1  carry-in (add) / borrow-in (sub)
out_valid  out  1  result valid
out_ready  in  1  result consumer ready
res_sum  out  WORDS*WORD_W  result
res_cout  out  1  carry-out (add) / borrow-out (sub)
res_ovf  out  1  signed two's-complement overflow of the full-width result
add_a  out  WORD_W  to adder a
add_b  out  WORD_W  to adder b
add_cin  out  1  to adder cin
add_sum  in  WORD_W  from adder sum (combinational, same cycle)
add_cout  in  1  from adder cout

Behaviour:
- FSM states: IDLE, RUN, DONE. Reset (checked before any other transition) -> IDLE. It wins over every in-flight operation; partial results are discarded.
- Values after reset: in_ready=1 (state IDLE), out_valid=0, res_sum=0, res_cout=0, res_ovf=0, idx=0, carry=0.
- IDLE:
  - in_ready=1.
  - On in_valid: latch op_a, op_b, op_sub.
  - Initialise carry: op_cin when op_sub=0, ~op_cin when op_sub=1.
  - Set idx=0 and go to RUN.
- RUN:
  - in_ready=0.
  - Drive add_a = A[idx], add_b = op_sub ? ~B[idx] : B[idx], add_cin = carry.
  - On each clock: res_sum word idx <= add_sum, carry <= add_cout, idx <= idx+1.
  - When idx == WORDS-1, capture and go to DONE:
    - res_cout = op_sub ? ~add_cout : add_cout.
    - res_ovf = (A_msb == B'_msb) && (add_sum[31] != A_msb), where B' is the possibly inverted B.
- add_a, add_b, add_cin are 0 outside RUN.
- DONE:
  - out_valid=1; res_sum, res_cout, res_ovf held stable.
  - On out_valid && out_ready: go to IDLE next cycle, out_valid drops.
  - in_valid is ignored while in RUN or DONE.
- Latency: handshake accepted at cycle 0 -> WORDS RUN cycles -> out_valid high in cycle WORDS+1.
- Throughput: one operation per WORDS+2 cycles minimum.
- res_sum is not cleared between operations; it is only meaningful while out_valid=1.
- idx width is clog2(WORDS); idx never wraps past WORDS-1.
- Operand registers are loaded only on an IDLE handshake; input changes at other times have no effect.

Decomposition:
- mp_add_pkg holds:
  - WORD_W constant (32).
  - state_t enum {IDLE, RUN, DONE}.
  - Word-select helper function.
- The sequencer contains no sub-module.
- A thin integration top, mp_adder_top, instantiates mp_add_sequencer plus Carry_look_ahead_adder (ports a, b, cin, sum, cout) and connects add_* to them.
- The bench tests mp_adder_top and also the sequencer alone against a behavioural adder model.

Test Plan:
- Add, all-ones wrap: a = 2^128-1, b = 1, cin=0, WORDS=4 -> res_sum = 0, res_cout=1, res_ovf=0; out_valid rises exactly 5 cycles after accept.
- Cross-word carry: a = 0x0..0_FFFFFFFF_FFFFFFFF, b = 1 -> res_sum = 0x0..1_00000000_00000000, res_cout=0.
- Subtract with borrow:
  - a = 0x1_00000000, b = 1, cin=0 -> res_sum = 0x0..0_FFFFFFFF, res_cout=0.
  - a = 0, b = 1 -> res_sum = 2^128-1, res_cout=1.
- Signed overflow: a = 0x7FFF..FFFF, b = 1, add -> res_sum = 0x8000..0000, res_ovf=1, res_cout=0.
- Backpressure: out_ready held low 10 cycles in DONE while in_valid pulses with new operands -> out_valid, res_sum, res_cout stable; in_ready=0; new operands not taken. A subsequent IDLE handshake is processed correctly.
- Reset mid-operation: assert rst for 1 cycle after 2 RUN cycles -> next cycle in_ready=1, out_valid=0, add_* = 0. The next operation (10+20, cin=1) -> res_sum = 31.
